// File: rtl/jt12_wr_pkg.sv
// Shared types and constants for the FM core CPU write port.
package jt12_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } wr_st_e;

  localparam logic [7:0] PRES_6 = 8'h2D;
  localparam logic [7:0] PRES_3 = 8'h2E;
  localparam logic [7:0] PRES_2 = 8'h2F;

  localparam logic [1:0] DIV_6 = 2'b10;
  localparam logic [1:0] DIV_3 = 2'b11;
  localparam logic [1:0] DIV_2 = 2'b00;

endpackage

// File: rtl/jt12_busy_cnt.sv
// Loadable 8-bit down-counter advanced only on FM clock enables; saturates at zero.
module jt12_busy_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clk_en,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clk_en) begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (i_dec && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/jt12_cpu_wr.sv
// CPU write port: edge-detects bus writes, holds one register write until the next
// FM clock enable, drives busy, and decodes prescaler address writes.
module jt12_cpu_wr
  import jt12_wr_pkg::*;
#(
  parameter int         num_ch   = 3,
  parameter int         BUSY_CNT = 32,
  parameter logic [1:0] DIV_RST  = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       reg_we,
  output logic       reg_part,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_din,
  output logic [1:0] div_setting
);

  localparam bit         PRES_EN = (num_ch != 6);
  localparam logic [7:0] CNT_LD  = 8'(BUSY_CNT - 1);

  logic       r_acc_l;
  logic [7:0] r_sh_addr;
  logic       r_sh_part;
  logic [1:0] r_div;
  wr_st_e     r_st;
  logic       r_busy;
  logic       r_part;
  logic [7:0] r_addr;
  logic [7:0] r_din;

  logic w_acc, w_accept, w_addr_wr, w_data_wr, w_issue, w_done;

  assign w_acc     = ~cs_n & ~wr_n;
  // Rising edge of the sampled access: one accept per bus cycle regardless of length.
  assign w_accept  = cen & w_acc & ~r_acc_l;
  assign w_addr_wr = w_accept & ~addr[0];
  assign w_data_wr = w_accept &  addr[0];
  assign w_issue   = (r_st == PEND) & clk_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_l   <= 1'b0;
      r_sh_addr <= 8'd0;
      r_sh_part <= 1'b0;
      r_div     <= DIV_RST;
    end else begin
      if (cen)
        r_acc_l <= w_acc;
      if (w_addr_wr) begin
        r_sh_addr <= din;
        r_sh_part <= addr[1];
        if (PRES_EN && !addr[1]) begin
          case (din)
            PRES_6:  r_div    <= DIV_6;
            PRES_3:  if (r_div[1]) r_div[0] <= 1'b1;
            PRES_2:  r_div    <= DIV_2;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= IDLE;
      r_busy <= 1'b0;
      r_part <= 1'b0;
      r_addr <= 8'd0;
      r_din  <= 8'd0;
    end else begin
      case (r_st)
        IDLE: if (w_data_wr) begin
          r_addr <= r_sh_addr;
          r_part <= r_sh_part;
          r_din  <= din;
          r_busy <= 1'b1;
          r_st   <= PEND;
        end
        PEND: if (clk_en) r_st <= BUSY;
        BUSY: if (clk_en && w_done) begin
          r_busy <= 1'b0;
          r_st   <= IDLE;
        end
        default: begin
          r_busy <= 1'b0;
          r_st   <= IDLE;
        end
      endcase
    end
  end

  jt12_busy_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clk_en   (clk_en),
    .i_load     (w_issue),
    .i_load_val (CNT_LD),
    .i_dec      (r_st == BUSY),
    .o_done     (w_done)
  );

  assign busy        = r_busy;
  assign reg_we      = w_issue;
  assign reg_part    = r_part;
  assign reg_addr    = r_addr;
  assign reg_din     = r_din;
  assign div_setting = r_div;

endmodule

// File: tb/tb_jt12_cpu_wr.sv
// Bench for jt12_cpu_wr: a 3-channel and a 6-channel instance share one bus.
module tb_jt12_cpu_wr;
  import jt12_wr_pkg::*;

  localparam int BC = 4;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b1, cs_n = 1'b1, wr_n = 1'b1;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       clk_en;
  int         cyc = 0, ph = 0;

  logic       busy3, we3, part3, busy6, we6, part6;
  logic [7:0] addr3, din3, addr6, din6;
  logic [1:0] div3, div6;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= (ph == 2) ? 0 : ph + 1;
  end
  assign clk_en = (ph == 0);

  jt12_cpu_wr #(.num_ch(3), .BUSY_CNT(BC), .DIV_RST(2'b11)) dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .busy(busy3), .reg_we(we3), .reg_part(part3),
    .reg_addr(addr3), .reg_din(din3), .div_setting(div3));

  jt12_cpu_wr #(.num_ch(6), .BUSY_CNT(BC), .DIV_RST(2'b11)) dut6 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .busy(busy6), .reg_we(we6), .reg_part(part6),
    .reg_addr(addr6), .reg_din(din6), .div_setting(div6));

  typedef struct {
    logic       part;
    logic [7:0] a;
    logic [7:0] d;
    int         acc;
  } exp_t;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [1:0] exp3;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   n_we = 0, n_we6 = 0, we6_cyc = -1, issue_cyc = -1, ticks = 0, last_ce = -1;
  logic [7:0] sh_a = 8'h00;
  logic       sh_p = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one bus cycle; the first cycle with cen high is the accepting one.
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d, input int hold,
                        input bit slow, input bit push);
    bit   got = 1'b0;
    exp_t e;
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cen = slow ? i[0] : 1'b1;
      if (cen && !got) begin
        got = 1'b1;
        if (!a[0]) begin
          sh_a = d;
          sh_p = a[1];
        end else if (push) begin
          e.part = sh_p; e.a = sh_a; e.d = d; e.acc = cyc;
          sb.push_back(e);
        end
      end
      tick();
    end
    cs_n = 1'b1; wr_n = 1'b1; cen = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy3 || busy6) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(busy3), 32'd0);
  endtask

  task automatic wait_ph(input int p);
    int n = 0;
    while (ph != p && n < 10) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard and tick accounting, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (we3) begin
      n_we++;
      if (sb.size() == 0) chk("spurious_we", 32'(we3), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("we_part", 32'(part3), 32'(e.part));
        chk("we_addr", 32'(addr3), 32'(e.a));
        chk("we_din", 32'(din3), 32'(e.d));
        chk("we_timing", 32'(cyc > e.acc && last_ce <= e.acc), 32'd1);
        issue_cyc = cyc;
        ticks = 0;
      end
    end else if (clk_en && busy3 && cyc > issue_cyc) ticks++;
    if (we6) begin
      n_we6++;
      we6_cyc = cyc;
    end
    if (clk_en) last_ce = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   acc;
    tbl[0] = '{2'b00, 8'h2D, 2'b10};
    tbl[1] = '{2'b00, 8'h2E, 2'b11};
    tbl[2] = '{2'b00, 8'h2F, 2'b00};
    tbl[3] = '{2'b00, 8'h2E, 2'b00};
    tbl[4] = '{2'b00, 8'h2D, 2'b10};
    tbl[5] = '{2'b10, 8'h2F, 2'b10};
    tbl[6] = '{2'b00, 8'h28, 2'b10};
    tbl[7] = '{2'b00, 8'h2E, 2'b11};

    repeat (3) tick();
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_we", 32'(we3), 32'd0);
    chk("rst_part", 32'(part3), 32'd0);
    chk("rst_addr", 32'(addr3), 32'd0);
    chk("rst_din", 32'(din3), 32'd0);
    chk("rst_div3", 32'(div3), 32'd3);
    chk("rst_div6", 32'(div6), 32'd3);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      bus_wr(tbl[i].a, tbl[i].d, 2, 1'b0, 1'b0);
      chk($sformatf("div3[%0d]", i), 32'(div3), 32'(tbl[i].exp3));
      chk($sformatf("div6[%0d]", i), 32'(div6), 32'd3);
      chk($sformatf("addr_busy[%0d]", i), 32'(busy3), 32'd0);
    end

    // Basic register write and busy duration
    bus_wr(2'b00, 8'h28, 2, 1'b0, 1'b0);
    bus_wr(2'b01, 8'h5A, 2, 1'b0, 1'b1);
    chk("busy_up", 32'(busy3), 32'd1);
    chk("out_addr", 32'(addr3), 32'h28);
    chk("out_din", 32'(din3), 32'h5A);
    chk("out_part", 32'(part3), 32'd0);
    wait_idle();
    chk("busy_ticks", 32'(ticks), 32'(BC));
    chk("n_we_1", 32'(n_we), 32'd1);

    // Second data write while busy is dropped; address write leaves reg_addr alone
    bus_wr(2'b01, 8'h11, 2, 1'b0, 1'b1);
    bus_wr(2'b01, 8'h22, 2, 1'b0, 1'b0);
    bus_wr(2'b00, 8'h30, 2, 1'b0, 1'b0);
    chk("addr_hold", 32'(addr3), 32'h28);
    wait_idle();
    chk("drop_din", 32'(din3), 32'h11);
    chk("n_we_2", 32'(n_we), 32'd2);

    // Long bus cycle with a slow cen gives a single accept
    bus_wr(2'b10, 8'h40, 2, 1'b0, 1'b0);
    bus_wr(2'b11, 8'h77, 10, 1'b1, 1'b1);
    wait_idle();
    chk("n_we_3", 32'(n_we), 32'd3);
    chk("long_part", 32'(part3), 32'd1);
    chk("long_addr", 32'(addr3), 32'h40);
    chk("long_din", 32'(din3), 32'h77);

    // Reset while a write is pending
    bus_wr(2'b00, 8'h2F, 2, 1'b0, 1'b0);
    chk("div_2", 32'(div3), 32'd0);
    wait_ph(1);
    addr = 2'b01; din = 8'h99; cs_n = 1'b0; wr_n = 1'b0;
    tick();
    cs_n = 1'b1; wr_n = 1'b1;
    chk("pend_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_now", 32'(busy3), 32'd0);
    chk("rst_div_now", 32'(div3), 32'd3);
    chk("rst_we_now", 32'(we3), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    sh_a = 8'h00; sh_p = 1'b0;
    repeat (12) tick();
    chk("n_we_rst", 32'(n_we), 32'd3);
    chk("n_we6_rst", 32'(n_we6), 32'd3);

    // Prescaler ignored for 6 channels; no bypass when accepted on a clk_en cycle
    bus_wr(2'b00, 8'h2F, 2, 1'b0, 1'b0);
    chk("div3_2f", 32'(div3), 32'd0);
    chk("div6_2f", 32'(div6), 32'd3);
    wait_ph(0);
    acc = cyc;
    bus_wr(2'b01, 8'h33, 2, 1'b0, 1'b1);
    wait_idle();
    chk("we6_cycle", 32'(we6_cyc), 32'(acc + 3));
    chk("n_we6", 32'(n_we6), 32'd4);
    chk("n_we_4", 32'(n_we), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
